fighter_player: RTL and testbench
=================================

Name: fighter_player

Overview:
Parametrised per-player fighter core. It replaces the fixed left/right player blocks with a single module, instantiated twice: SIDE=0 for the left player and SIDE=1 for the right.
- Tracks location, health, regen and an action state machine (ACTIVE/AIR/STUNNED/KO).
- Resolves incoming hits from the opponent's command and location.
- Sits between input decode and the display/referee logic. All outputs are registered.

Parameters:
SIDE, 1, 0 = left player, 1 = right player; selects which MOVE opcode means "away".
POS_W, 3, location width.
ARENA_MAX, 2, max location (distance from centre); also the reset location.
HP_W, 3, health width.
HP_INIT, 3, health at reset.
HP_MAX, 7, health saturation ceiling (≤ 2^HP_W-1).
PUNCH_DMG, 2, punch damage.
KICK_DMG, 1, kick damage.
PUNCH_RANGE, 0, max gap at which a punch lands.
KICK_RANGE, 1, max gap at which a kick lands.
REGEN_WAIT, 2, consecutive WAIT cycles per +1 HP.
STUN_CYCLES, 2, cycles in STUNNED after damage.
JUMP_CYCLES, 2, cycles in AIR after JUMP.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
freeze  in  1  pause: when high, all state is held.
own_cmd  in  6  own one-hot command.
opp_cmd  in  6  opponent one-hot command.
opp_loc  in  POS_W  opponent location.
loc_out  out  POS_W  own location.
hp_out  out  HP_W  own health.
state_out  out  2  0=ACTIVE, 1=AIR, 2=STUNNED, 3=KO.
hit_pulse  out  1  one-cycle pulse on a damaging hit.
ko  out  1  high while in KO.

Behaviour:
- Opcodes: MOVE_RIGHT 100000, MOVE_LEFT 010000, WAIT 001000, JUMP 000100, KICK 000010, PUNCH 000001. Any other value (zero or multi-hot) is a NOP.
- "Away" = MOVE_RIGHT if SIDE=1, MOVE_LEFT if SIDE=0; the other move is "toward".
- Reset (rst_n low at posedge clk, overrides freeze): loc_out=ARENA_MAX, hp_out=HP_INIT, state=ACTIVE, hit_pulse=0, ko=0; wait/stun/air counters cleared.
- freeze high: every register holds, hit_pulse forced 0.
- gap = loc_out + opp_loc, computed at POS_W+1 bits (no overflow).
- Incoming attack: opp_cmd=PUNCH with gap≤PUNCH_RANGE, or opp_cmd=KICK with gap≤KICK_RANGE. Only evaluated in ACTIVE; own_cmd=JUMP that same cycle evades it.
- ACTIVE with an incoming attack:
  - PUNCH vs own PUNCH: pushback.
  - KICK vs own KICK: pushback.
  - KICK vs own PUNCH: blocked, no change.
  - Otherwise: damage.
  - Pushback: loc+1, saturating at ARENA_MAX; no damage.
  - Damage: hp -= DMG, saturating at 0; hit_pulse=1 next cycle; wait counter cleared. If the result is 0: KO, else STUNNED with stun counter = STUN_CYCLES.
  - Own move/WAIT/JUMP is discarded in any attack cycle.
- ACTIVE, no attack:
  - toward: loc-1 if loc>0, else hold.
  - away: loc+1 if loc<ARENA_MAX, else hold.
  - JUMP: enter AIR with air counter = JUMP_CYCLES.
  - WAIT: wait counter +1. On reaching REGEN_WAIT: hp+1 (saturating at HP_MAX) and counter returns to 0.
  - Any non-WAIT command (including NOP) clears the wait counter.
- AIR: immune to attacks, own_cmd ignored. Counter decrements; leaves to ACTIVE on the cycle the counter reaches 0, so it spends exactly JUMP_CYCLES cycles in AIR.
- STUNNED: immune to attacks, own_cmd ignored. Spends exactly STUN_CYCLES cycles, then ACTIVE.
- KO: terminal until reset. hp_out=0, ko=1, location frozen, all inputs ignored.
- hit_pulse is high only in the cycle after damage is applied; never two consecutive cycles.
- Reset mid-AIR/STUNNED/KO returns to ACTIVE with reset values on the next edge.

Test Plan:
Defaults, SIDE=1 unless noted.
1. Reset: hold rst_n=0 two cycles -> loc_out=2, hp_out=3, state_out=0, ko=0, hit_pulse=0. Repeat with freeze=1 -> same values.
2. Movement: MOVE_LEFT x3 -> loc 1, 0, 0 (saturates); MOVE_RIGHT x3 -> 1, 2, 2. With SIDE=0, MOVE_RIGHT x3 -> 1, 0, 0.
3. Punch to KO: loc 0, opp_loc 0, opp PUNCH, own WAIT -> hp 1, hit_pulse 1 for one cycle, state 2 for 2 cycles (repeat punches ignored), then 0. Second punch -> hp 0, state 3, ko 1; MOVE/WAIT afterwards change nothing until reset.
4. Kick clash: loc 0, opp_loc 1, opp KICK + own KICK -> loc 1, hp 3, hit_pulse 0. Opp KICK + own PUNCH at gap 1 -> no change. Opp PUNCH at gap 1 -> no change.
5. Regen: WAIT x4 from hp 3 -> hp 3, 4, 4, 5. WAIT, NOP, WAIT -> hp unchanged. WAIT x8 from hp 6 -> saturates at 7.
6. Jump/freeze: own JUMP with opp PUNCH at gap 0 -> no damage, state 1 for 2 cycles, punches ignored, then 0. freeze=1 for 3 cycles during STUNNED -> counters and outputs held, stun resumes after release.

Source files
------------

// File: rtl/fighter_player.sv
// One fighter: tracks location, health, regen and an ACTIVE/AIR/STUNNED/KO
// action state machine, and resolves the opponent's attacks. All outputs are registered.
module fighter_player #(
  parameter int SIDE        = 1,
  parameter int POS_W       = 3,
  parameter int ARENA_MAX   = 2,
  parameter int HP_W        = 3,
  parameter int HP_INIT     = 3,
  parameter int HP_MAX      = 7,
  parameter int PUNCH_DMG   = 2,
  parameter int KICK_DMG    = 1,
  parameter int PUNCH_RANGE = 0,
  parameter int KICK_RANGE  = 1,
  parameter int REGEN_WAIT  = 2,
  parameter int STUN_CYCLES = 2,
  parameter int JUMP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic [5:0]       own_cmd,
  input  logic [5:0]       opp_cmd,
  input  logic [POS_W-1:0] opp_loc,
  output logic [POS_W-1:0] loc_out,
  output logic [HP_W-1:0]  hp_out,
  output logic [1:0]       state_out,
  output logic             hit_pulse,
  output logic             ko
);

  localparam int GW = POS_W + 1;

  localparam logic [5:0] OP_MR    = 6'b100000;
  localparam logic [5:0] OP_ML    = 6'b010000;
  localparam logic [5:0] OP_WAIT  = 6'b001000;
  localparam logic [5:0] OP_JUMP  = 6'b000100;
  localparam logic [5:0] OP_KICK  = 6'b000010;
  localparam logic [5:0] OP_PUNCH = 6'b000001;
  localparam logic [5:0] OP_AWAY   = (SIDE == 1) ? OP_MR : OP_ML;
  localparam logic [5:0] OP_TOWARD = (SIDE == 1) ? OP_ML : OP_MR;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_AIR    = 2'd1;
  localparam logic [1:0] ST_STUN   = 2'd2;
  localparam logic [1:0] ST_KO     = 2'd3;

  localparam logic [POS_W-1:0] L_AMAX   = POS_W'(ARENA_MAX);
  localparam logic [GW-1:0]    L_PRANGE = GW'(PUNCH_RANGE);
  localparam logic [GW-1:0]    L_KRANGE = GW'(KICK_RANGE);
  localparam logic [HP_W-1:0]  L_HPINIT = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]  L_HPMAX  = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  L_PDMG   = HP_W'(PUNCH_DMG);
  localparam logic [HP_W-1:0]  L_KDMG   = HP_W'(KICK_DMG);
  localparam logic [7:0]       L_REGEN  = 8'(REGEN_WAIT);
  localparam logic [7:0]       L_STUN   = 8'(STUN_CYCLES);
  localparam logic [7:0]       L_JUMP   = 8'(JUMP_CYCLES);

  logic [POS_W-1:0] r_loc;
  logic [HP_W-1:0]  r_hp;
  logic [1:0]       r_state;
  logic             r_hit;
  logic             r_ko;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       r_stun_cnt;
  logic [7:0]       r_air_cnt;

  logic [GW-1:0]   w_gap;
  logic            w_opp_punch;
  logic            w_opp_kick;
  logic            w_attack;
  logic            w_clash;
  logic            w_block;
  logic [HP_W-1:0] w_dmg;
  logic [HP_W-1:0] w_hp_hit;

  // Locations are distances from centre, so the gap between players is their sum.
  assign w_gap       = {1'b0, r_loc} + {1'b0, opp_loc};
  assign w_opp_punch = (opp_cmd == OP_PUNCH);
  assign w_opp_kick  = (opp_cmd == OP_KICK);
  assign w_attack    = (w_opp_punch && (w_gap <= L_PRANGE)) ||
                       (w_opp_kick  && (w_gap <= L_KRANGE));
  assign w_clash     = (w_opp_punch && own_cmd == OP_PUNCH) ||
                       (w_opp_kick  && own_cmd == OP_KICK);
  assign w_block     = w_opp_kick && (own_cmd == OP_PUNCH);
  assign w_dmg       = w_opp_punch ? L_PDMG : L_KDMG;
  assign w_hp_hit    = (r_hp > w_dmg) ? (r_hp - w_dmg) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loc      <= L_AMAX;
      r_hp       <= L_HPINIT;
      r_state    <= ST_ACTIVE;
      r_hit      <= 1'b0;
      r_ko       <= 1'b0;
      r_wait_cnt <= '0;
      r_stun_cnt <= '0;
      r_air_cnt  <= '0;
    end else if (freeze) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        ST_ACTIVE: begin
          if (w_attack && own_cmd != OP_JUMP) begin
            r_wait_cnt <= '0;
            if (w_clash) begin
              if (r_loc < L_AMAX) r_loc <= r_loc + 1'b1;
            end else if (!w_block) begin
              r_hp  <= w_hp_hit;
              r_hit <= 1'b1;
              if (w_hp_hit == '0) begin
                r_state <= ST_KO;
                r_ko    <= 1'b1;
              end else begin
                r_state    <= ST_STUN;
                r_stun_cnt <= L_STUN;
              end
            end
          end else if (own_cmd == OP_JUMP) begin
            r_wait_cnt <= '0;
            r_state    <= ST_AIR;
            r_air_cnt  <= L_JUMP;
          end else if (own_cmd == OP_WAIT) begin
            if ((r_wait_cnt + 8'd1) >= L_REGEN) begin
              r_wait_cnt <= '0;
              if (r_hp < L_HPMAX) r_hp <= r_hp + 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end else begin
            r_wait_cnt <= '0;
            if (own_cmd == OP_TOWARD && r_loc != '0) r_loc <= r_loc - 1'b1;
            else if (own_cmd == OP_AWAY && r_loc < L_AMAX) r_loc <= r_loc + 1'b1;
          end
        end
        // Leaving on the decrement to zero gives exactly N cycles in the state.
        ST_AIR: begin
          if (r_air_cnt <= 8'd1) begin
            r_air_cnt <= '0;
            r_state   <= ST_ACTIVE;
          end else begin
            r_air_cnt <= r_air_cnt - 8'd1;
          end
        end
        ST_STUN: begin
          if (r_stun_cnt <= 8'd1) begin
            r_stun_cnt <= '0;
            r_state    <= ST_ACTIVE;
          end else begin
            r_stun_cnt <= r_stun_cnt - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign loc_out   = r_loc;
  assign hp_out    = r_hp;
  assign state_out = r_state;
  assign hit_pulse = r_hit;
  assign ko        = r_ko;

endmodule

// File: tb/tb_fighter_player.sv
// Bench for fighter_player: one left and one right instance share stimulus and
// are checked every cycle against a rule-level model, plus directed literal checks.
module tb_fighter_player;

  localparam logic [5:0] MR    = 6'b100000;
  localparam logic [5:0] ML    = 6'b010000;
  localparam logic [5:0] WT    = 6'b001000;
  localparam logic [5:0] JP    = 6'b000100;
  localparam logic [5:0] KK    = 6'b000010;
  localparam logic [5:0] PN    = 6'b000001;
  localparam logic [5:0] NOP   = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       freeze = 1'b0;
  logic [5:0] own_cmd = NOP;
  logic [5:0] opp_cmd = NOP;
  logic [2:0] opp_loc = 3'd0;

  logic [2:0] loc1, loc0;
  logic [2:0] hp1, hp0;
  logic [1:0] st1, st0;
  logic       hit1, hit0, ko1, ko0;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  check_en = 1'b0;

  int  m_loc [2];
  int  m_hp  [2];
  int  m_st  [2];
  int  m_wait[2];
  int  m_tmr [2];
  bit  m_hit [2];

  always #5 clk = ~clk;

  fighter_player #(.SIDE(1)) u_right (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .own_cmd(own_cmd),
    .opp_cmd(opp_cmd), .opp_loc(opp_loc), .loc_out(loc1), .hp_out(hp1),
    .state_out(st1), .hit_pulse(hit1), .ko(ko1)
  );

  fighter_player #(.SIDE(0)) u_left (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .own_cmd(own_cmd),
    .opp_cmd(opp_cmd), .opp_loc(opp_loc), .loc_out(loc0), .hp_out(hp0),
    .state_out(st0), .hit_pulse(hit0), .ko(ko0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: state 0=ACTIVE 1=AIR 2=STUNNED 3=KO; m_tmr = cycles left in AIR/STUNNED.
  task automatic model_step(input int p, input int side);
    int gap;
    bit attack;
    logic [5:0] away, toward;
    away   = (side == 1) ? MR : ML;
    toward = (side == 1) ? ML : MR;
    m_hit[p] = 1'b0;
    if (!rst_n) begin
      m_loc[p] = 2; m_hp[p] = 3; m_st[p] = 0; m_wait[p] = 0; m_tmr[p] = 0;
    end else if (!freeze) begin
      if (m_st[p] == 1 || m_st[p] == 2) begin
        m_tmr[p]--;
        if (m_tmr[p] <= 0) m_st[p] = 0;
      end else if (m_st[p] == 0) begin
        gap = m_loc[p] + int'(opp_loc);
        attack = (opp_cmd == PN && gap <= 0) || (opp_cmd == KK && gap <= 1);
        if (attack && own_cmd != JP) begin
          m_wait[p] = 0;
          if (opp_cmd == own_cmd) begin
            if (m_loc[p] < 2) m_loc[p]++;
          end else if (!(opp_cmd == KK && own_cmd == PN)) begin
            m_hp[p] = m_hp[p] - ((opp_cmd == PN) ? 2 : 1);
            if (m_hp[p] < 0) m_hp[p] = 0;
            m_hit[p] = 1'b1;
            if (m_hp[p] == 0) m_st[p] = 3;
            else begin m_st[p] = 2; m_tmr[p] = 2; end
          end
        end else if (own_cmd == JP) begin
          m_wait[p] = 0; m_st[p] = 1; m_tmr[p] = 2;
        end else if (own_cmd == WT) begin
          m_wait[p]++;
          if (m_wait[p] == 2) begin
            m_wait[p] = 0;
            if (m_hp[p] < 7) m_hp[p]++;
          end
        end else begin
          m_wait[p] = 0;
          if (own_cmd == toward && m_loc[p] > 0) m_loc[p]--;
          else if (own_cmd == away && m_loc[p] < 2) m_loc[p]++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 0);
    model_step(1, 1);
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("right.loc", int'(loc1), m_loc[1]);
      chk("right.hp",  int'(hp1),  m_hp[1]);
      chk("right.state", int'(st1), m_st[1]);
      chk("right.hit", int'(hit1), int'(m_hit[1]));
      chk("right.ko",  int'(ko1),  (m_st[1] == 3) ? 1 : 0);
      chk("left.loc",  int'(loc0), m_loc[0]);
      chk("left.hp",   int'(hp0),  m_hp[0]);
      chk("left.state", int'(st0), m_st[0]);
      chk("left.hit",  int'(hit0), int'(m_hit[0]));
      chk("left.ko",   int'(ko0),  (m_st[0] == 3) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs and return at the next falling edge.
  task automatic cyc(input logic [5:0] own, input logic [5:0] opp, input logic [2:0] ol);
    own_cmd = own; opp_cmd = opp; opp_loc = ol;
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input int loc, input int hp, input int st, input int hit);
    chk({tag, ".loc"}, int'(loc1), loc);
    chk({tag, ".hp"},  int'(hp1),  hp);
    chk({tag, ".state"}, int'(st1), st);
    chk({tag, ".hit"}, int'(hit1), hit);
    chk({tag, ".ko"},  int'(ko1),  (st == 3) ? 1 : 0);
  endtask

  initial begin
    // Reset, then reset again under freeze after a move.
    rst_n = 1'b0;
    cyc(NOP, NOP, 0);
    check_en = 1'b1;
    cyc(NOP, NOP, 0);
    lit("reset", 2, 3, 0, 0);
    rst_n = 1'b1;
    cyc(ML, NOP, 0);
    lit("pre_frz_rst", 1, 3, 0, 0);
    rst_n = 1'b0; freeze = 1'b1;
    cyc(ML, NOP, 0);
    lit("frz_rst", 2, 3, 0, 0);
    rst_n = 1'b1; freeze = 1'b0;

    // Movement with saturation on both sides.
    cyc(ML, NOP, 0); lit("ml1", 1, 3, 0, 0); chk("left.ml1", int'(loc0), 2);
    cyc(ML, NOP, 0); lit("ml2", 0, 3, 0, 0);
    cyc(ML, NOP, 0); lit("ml3", 0, 3, 0, 0);
    cyc(MR, NOP, 0); lit("mr1", 1, 3, 0, 0); chk("left.mr1", int'(loc0), 1);
    cyc(MR, NOP, 0); lit("mr2", 2, 3, 0, 0); chk("left.mr2", int'(loc0), 0);
    cyc(MR, NOP, 0); lit("mr3", 2, 3, 0, 0); chk("left.mr3", int'(loc0), 0);

    // Punch to KO.
    cyc(ML, NOP, 0); cyc(ML, NOP, 0);
    cyc(WT, PN, 0); lit("punch1", 0, 1, 2, 1);
    cyc(WT, PN, 0); lit("stun1", 0, 1, 2, 0);
    cyc(WT, PN, 0); lit("stun_end", 0, 1, 0, 0);
    cyc(WT, PN, 0); lit("punch_ko", 0, 0, 3, 1);
    cyc(MR, NOP, 0); lit("ko_move", 0, 0, 3, 0);
    cyc(WT, NOP, 0); cyc(WT, NOP, 0); lit("ko_wait", 0, 0, 3, 0);
    rst_n = 1'b0;
    cyc(NOP, NOP, 0); lit("ko_reset", 2, 3, 0, 0);
    rst_n = 1'b1;

    // Kick clash, block, out-of-range punch.
    cyc(ML, NOP, 0); cyc(ML, NOP, 0);
    cyc(KK, KK, 1); lit("kick_clash", 1, 3, 0, 0);
    cyc(PN, KK, 0); lit("kick_block", 1, 3, 0, 0);
    cyc(NOP, PN, 0); lit("punch_far", 1, 3, 0, 0);

    // Regeneration.
    cyc(WT, NOP, 0); lit("regen1", 1, 3, 0, 0);
    cyc(WT, NOP, 0); lit("regen2", 1, 4, 0, 0);
    cyc(WT, NOP, 0); lit("regen3", 1, 4, 0, 0);
    cyc(WT, NOP, 0); lit("regen4", 1, 5, 0, 0);
    cyc(WT, NOP, 0); cyc(NOP, NOP, 0); cyc(WT, NOP, 0); lit("regen_break", 1, 5, 0, 0);
    for (int i = 0; i < 10; i++) cyc(WT, NOP, 0);
    lit("regen_sat", 1, 7, 0, 0);

    // Jump evasion, then stun held by freeze.
    cyc(ML, NOP, 0); cyc(ML, NOP, 0);
    cyc(JP, PN, 0); lit("jump1", 0, 7, 1, 0);
    cyc(NOP, PN, 0); lit("jump2", 0, 7, 1, 0);
    cyc(NOP, PN, 0); lit("land", 0, 7, 0, 0);
    cyc(NOP, PN, 0); lit("hit_after_land", 0, 5, 2, 1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(NOP, PN, 0); lit("frozen", 0, 5, 2, 0);
    end
    freeze = 1'b0;
    cyc(NOP, NOP, 0); lit("stun_resume", 0, 5, 2, 0);
    cyc(NOP, NOP, 0); lit("stun_done", 0, 5, 0, 0);

    // Random phase against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] ops [8];
      ops[0] = MR; ops[1] = ML; ops[2] = WT; ops[3] = JP;
      ops[4] = KK; ops[5] = PN; ops[6] = NOP; ops[7] = 6'b000011;
      rst_n  = ($urandom_range(0, 99) >= 3);
      freeze = ($urandom_range(0, 99) < 8);
      cyc(ops[$urandom_range(0, 7)], ops[$urandom_range(0, 7)], 3'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
